// File: rtl/genius_pkg.sv
// rtl/genius_pkg.sv - shared types and default sizing for the Genius game input path
package genius_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        RED    = 2'd1,
        BLUE   = 2'd2,
        YELLOW = 2'd3
    } color_e;

    localparam int NUM_BUTTONS_DEF     = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int FIFO_DEPTH_DEF      = 4;

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - one button channel: two-flop synchroniser, disagreement counter, stable level
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            if (sync_b == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                // The increment that would reach the threshold flips the level instead.
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_input_unit.sv
// rtl/button_input_unit.sv - debounced, gated button presses queued as indices behind a valid/ready port
module button_input_unit
    import genius_pkg::*;
#(
    parameter int NUM_BUTTONS     = NUM_BUTTONS_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF,
    localparam int IDX_W          = $clog2(NUM_BUTTONS),
    localparam int CNT_W          = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_BUTTONS-1:0] buttons_raw,
    input  logic                   player_wr,
    input  logic                   flush,
    input  logic                   press_ready,
    output logic                   press_valid,
    output logic [IDX_W-1:0]       press_index,
    output logic [CNT_W-1:0]       fifo_count,
    output logic [NUM_BUTTONS-1:0] stable_vec,
    output logic                   multi_err,
    output logic                   overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int POP_W = $clog2(NUM_BUTTONS + 1);

    logic [NUM_BUTTONS-1:0] stable_prev;
    logic [NUM_BUTTONS-1:0] edge_vec;
    logic [POP_W-1:0]       pop_cnt;
    logic [IDX_W-1:0]       enc;
    logic [IDX_W-1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   full;
    logic                   pop;
    logic                   push_req;
    logic                   do_push;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .raw   (buttons_raw[g]),
            .stable(stable_vec[g])
        );
    end

    assign edge_vec = stable_vec & ~stable_prev;

    always_comb begin
        pop_cnt = '0;
        enc     = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            pop_cnt = pop_cnt + POP_W'(edge_vec[i]);
            if (edge_vec[i]) begin
                enc = IDX_W'(i);
            end
        end
    end

    assign press_valid = (fifo_count != '0);
    assign press_index = mem[rd_ptr];
    assign full        = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign pop         = press_valid & press_ready;
    assign push_req    = player_wr && (pop_cnt == POP_W'(1));
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push     = push_req && !flush && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_prev <= '0;
            multi_err   <= 1'b0;
            overflow    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            stable_prev <= stable_vec;
            multi_err   <= player_wr && (pop_cnt > POP_W'(1));
            overflow    <= push_req && !flush && full && !pop;
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= enc;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({do_push, pop})
                    2'b10:   fifo_count <= fifo_count + 1'b1;
                    2'b01:   fifo_count <= fifo_count - 1'b1;
                    default: fifo_count <= fifo_count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_input_unit.sv
// tb/tb_button_input_unit.sv - directed checks of debounce latency, gating, classification, queue and flush
module tb_button_input_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] buttons_raw;
    logic       player_wr;
    logic       flush;
    logic       press_ready;
    logic       press_valid;
    logic [1:0] press_index;
    logic [2:0] fifo_count;
    logic [3:0] stable_vec;
    logic       multi_err;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    button_input_unit dut (
        .clk        (clk),
        .rst        (rst),
        .buttons_raw(buttons_raw),
        .player_wr  (player_wr),
        .flush      (flush),
        .press_ready(press_ready),
        .press_valid(press_valid),
        .press_index(press_index),
        .fifo_count (fifo_count),
        .stable_vec (stable_vec),
        .multi_err  (multi_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_one();
        press_ready = 1'b1;
        tick(1);
        press_ready = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        buttons_raw = 4'b0000;
        player_wr   = 1'b1;
        flush       = 1'b0;
        press_ready = 1'b0;
        tick(2);
        check("reset_valid", press_valid, 0);
        check("reset_index", press_index, 0);
        check("reset_count", fifo_count, 0);
        check("reset_stable", stable_vec, 0);
        check("reset_multi", multi_err, 0);
        check("reset_ovf", overflow, 0);
        rst = 1'b0;
        tick(2);

        // Red: stable after 18 edges, entry after 19
        buttons_raw = 4'b0010;
        tick(17);
        check("red_stable_early", stable_vec, 4'b0000);
        tick(1);
        check("red_stable", stable_vec, 4'b0010);
        check("red_valid_early", press_valid, 0);
        tick(1);
        check("red_valid", press_valid, 1);
        check("red_index", press_index, 1);
        check("red_count", fifo_count, 1);
        buttons_raw = 4'b0000;
        tick(20);
        check("red_release_count", fifo_count, 1);
        check("red_release_stable", stable_vec, 0);
        pop_one();
        check("red_pop", fifo_count, 0);

        // Blue bounces with 5-cycle glitches, then holds
        for (int s = 0; s < 12; s++) begin
            buttons_raw = (s % 2 == 0) ? 4'b0100 : 4'b0000;
            tick(5);
        end
        check("bounce_stable", stable_vec, 0);
        check("bounce_count", fifo_count, 0);
        buttons_raw = 4'b0100;
        tick(18);
        check("bounce_valid_early", press_valid, 0);
        tick(1);
        check("bounce_count_one", fifo_count, 1);
        check("bounce_index", press_index, 2);
        buttons_raw = 4'b0000;
        tick(20);
        check("bounce_single", fifo_count, 1);
        pop_one();

        // Green + yellow together
        buttons_raw = 4'b1001;
        tick(19);
        check("multi_pulse", multi_err, 1);
        check("multi_count", fifo_count, 0);
        tick(1);
        check("multi_pulse_end", multi_err, 0);
        buttons_raw = 4'b0000;
        tick(20);

        // Yellow pressed while disabled, then enable while held
        player_wr   = 1'b0;
        buttons_raw = 4'b1000;
        tick(25);
        player_wr = 1'b1;
        tick(5);
        check("gate_held", fifo_count, 0);
        buttons_raw = 4'b0000;
        tick(20);
        check("gate_release", fifo_count, 0);
        buttons_raw = 4'b1000;
        tick(19);
        check("gate_repress_count", fifo_count, 1);
        check("gate_repress_index", press_index, 3);
        buttons_raw = 4'b0000;
        tick(20);
        pop_one();
        check("gate_pop", fifo_count, 0);

        // Fill the queue with 0,1,2,3
        for (int b = 0; b < 4; b++) begin
            buttons_raw = 4'(1 << b);
            tick(19);
            buttons_raw = 4'b0000;
            tick(20);
        end
        check("full_count", fifo_count, 4);
        check("full_head", press_index, 0);
        buttons_raw = 4'b0010;
        tick(19);
        check("ovf_pulse", overflow, 1);
        check("ovf_count", fifo_count, 4);
        tick(1);
        check("ovf_pulse_end", overflow, 0);
        buttons_raw = 4'b0000;
        tick(20);

        // Push coinciding with a pop while full
        buttons_raw = 4'b0001;
        tick(18);
        press_ready = 1'b1;
        tick(1);
        press_ready = 1'b0;
        check("pp_ovf", overflow, 0);
        check("pp_count", fifo_count, 4);
        check("pp_head", press_index, 1);
        tick(1);
        check("pp_ovf_after", overflow, 0);
        buttons_raw = 4'b0000;
        tick(20);

        // Drain order 1,2,3,0 partially, then flush with 3 queued
        pop_one();
        check("pre_flush_count", fifo_count, 3);
        check("pre_flush_head", press_index, 2);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("flush_count", fifo_count, 0);
        check("flush_valid", press_valid, 0);

        // Flush wins over a same-cycle push
        buttons_raw = 4'b0100;
        tick(18);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("flushpush_count", fifo_count, 0);
        check("flushpush_ovf", overflow, 0);
        buttons_raw = 4'b0000;
        tick(20);

        // Queue one entry, then reset in the middle of debouncing another
        buttons_raw = 4'b0010;
        tick(19);
        check("prerst_count", fifo_count, 1);
        buttons_raw = 4'b0000;
        tick(20);
        buttons_raw = 4'b0100;
        tick(10);
        #2;
        rst = 1'b1;
        #1;
        check("rst_valid", press_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_index", press_index, 0);
        check("rst_stable", stable_vec, 0);
        buttons_raw = 4'b0000;
        tick(1);
        rst = 1'b0;
        tick(30);
        check("post_rst_count", fifo_count, 0);
        check("post_rst_stable", stable_vec, 0);
        check("post_rst_multi", multi_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
